// File: rtl/hm_10_state_line_generator_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hm10_pkg
// Description : Shared definitions for the HM-10 STATE line generator:
//               link_state encodings, counter width, default timing and the
//               internal FSM state type.
// Revision    : 1.0 - initial release
// ============================================================================
package hm10_pkg;

    // Externally visible link_state encodings (shared with the checker)
    localparam logic [1:0] LS_OFF        = 2'b00;
    localparam logic [1:0] LS_ADVERTISE  = 2'b01;
    localparam logic [1:0] LS_CONNECTING = 2'b10;
    localparam logic [1:0] LS_CONNECTED  = 2'b11;

    // Width of every timing counter
    localparam int CNT_W = 32;

    // Default timing, in clock cycles
    localparam int unsigned DEFAULT_HALF_PERIOD     = 500000;
    localparam int unsigned DEFAULT_CONNECT_DELAY   = 1000;
    localparam int unsigned DEFAULT_DISCONNECT_HOLD = 2000;

    // Internal FSM states; DROPPED is hidden behind the OFF encoding
    typedef enum logic [2:0] {
        ST_OFF        = 3'd0,
        ST_ADVERTISE  = 3'd1,
        ST_CONNECTING = 3'd2,
        ST_CONNECTED  = 3'd3,
        ST_DROPPED    = 3'd4
    } gen_state_t;

    // Map an internal state onto its reported link_state encoding
    function automatic logic [1:0] link_code(input gen_state_t s);
        logic [1:0] code;
        code = LS_OFF;
        case (s)
            ST_ADVERTISE:  code = LS_ADVERTISE;
            ST_CONNECTING: code = LS_CONNECTING;
            ST_CONNECTED:  code = LS_CONNECTED;
            default:       code = LS_OFF;
        endcase
        return code;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hm_10_state_line_generator_if.sv
`default_nettype none
// ============================================================================
// Module      : hm_10_state_line_generator_if
// Description : Control/status bundle between a BLE "central" (master) and
//               the HM-10 STATE line generator (slave).
//               Optional macro HM10_STATE_GEN_TOGGLE_COUNT_EN adds toggle_count.
// Revision    : 1.0 - initial release
// ============================================================================
interface hm_10_state_line_generator_if;

    logic        power_enable;
    logic        connect_request;
    logic        force_drop;
    logic        state_line;
    logic [1:0]  link_state;
    logic        connected;
`ifdef HM10_STATE_GEN_TOGGLE_COUNT_EN
    logic [15:0] toggle_count;
`endif

`ifdef HM10_STATE_GEN_TOGGLE_COUNT_EN
    modport master (
        output power_enable, connect_request, force_drop,
        input  state_line, link_state, connected, toggle_count
    );
    modport slave (
        input  power_enable, connect_request, force_drop,
        output state_line, link_state, connected, toggle_count
    );
`else
    modport master (
        output power_enable, connect_request, force_drop,
        input  state_line, link_state, connected
    );
    modport slave (
        input  power_enable, connect_request, force_drop,
        output state_line, link_state, connected
    );
`endif

endinterface
`default_nettype wire

// File: rtl/hm_10_state_line_generator_terminal_count_counter.sv
`default_nettype none
// ============================================================================
// Module      : terminal_count_counter
// Description : Up-counter with synchronous clear and enable that wraps at a
//               runtime limit; o_done flags the enabled terminal-count cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module terminal_count_counter
    import hm10_pkg::*;
#(
    parameter int WIDTH = CNT_W
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_clear,
    input  wire logic             i_en,
    input  wire logic [WIDTH-1:0] i_limit,
    output logic                  o_done
);

    logic [WIDTH-1:0] r_count;
    logic             w_terminal;

    assign w_terminal = (r_count == (i_limit - WIDTH'(1)));
    assign o_done     = i_en && w_terminal;

    // Count 0..limit-1 while enabled; clear has priority over counting
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= w_terminal ? '0 : r_count + WIDTH'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/hm_10_state_line_generator.sv
`default_nettype none
// ============================================================================
// Module      : hm_10_state_line_generator
// Description : Emulates the HM-10 BLE STATE pin: blinks while advertising or
//               connecting, steady high when connected, low for a hold time
//               after a link drop. All outputs registered from next state.
//               Optional macro HM10_STATE_GEN_TOGGLE_COUNT_EN adds a 16-bit
//               state_line transition counter.
// Revision    : 1.0 - initial release
// ============================================================================
module hm_10_state_line_generator
    import hm10_pkg::*;
#(
    parameter int unsigned HALF_PERIOD     = DEFAULT_HALF_PERIOD,
    parameter int unsigned CONNECT_DELAY   = DEFAULT_CONNECT_DELAY,
    parameter int unsigned DISCONNECT_HOLD = DEFAULT_DISCONNECT_HOLD
) (
    input  wire logic               clock,
    input  wire logic               reset,
    hm_10_state_line_generator_if.slave bus
);

    localparam logic [CNT_W-1:0] C_HALF_LIMIT  = CNT_W'(HALF_PERIOD);
    localparam logic [CNT_W-1:0] C_DELAY_LIMIT = CNT_W'(CONNECT_DELAY);
    localparam logic [CNT_W-1:0] C_HOLD_LIMIT  = CNT_W'(DISCONNECT_HOLD);

    gen_state_t r_state;
    logic       r_blink;
    logic       r_line;
    logic [1:0] r_link;
    logic       r_conn;
`ifdef HM10_STATE_GEN_TOGGLE_COUNT_EN
    logic [15:0] r_toggle_cnt;
`endif

    gen_state_t w_state_nxt;
    logic       w_blink_nxt;
    logic       w_line_nxt;
    logic       w_in_blink;
    logic       w_nxt_blink;
    logic       w_blink_done;
    logic       w_delay_done;
    logic       w_hold_done;

    assign w_in_blink  = (r_state == ST_ADVERTISE) || (r_state == ST_CONNECTING);
    assign w_nxt_blink = (w_state_nxt == ST_ADVERTISE) || (w_state_nxt == ST_CONNECTING);

    // Blink phase survives ADVERTISE<->CONNECTING; restarts from 0 on any entry
    terminal_count_counter #(.WIDTH(CNT_W)) u_blink_cnt (
        .clk     (clock),
        .rst     (reset),
        .i_clear (!bus.power_enable || !w_in_blink),
        .i_en    (w_in_blink),
        .i_limit (C_HALF_LIMIT),
        .o_done  (w_blink_done)
    );

    // Connect delay restarts whenever the request is withdrawn
    terminal_count_counter #(.WIDTH(CNT_W)) u_delay_cnt (
        .clk     (clock),
        .rst     (reset),
        .i_clear (!bus.power_enable || (r_state != ST_CONNECTING) || !bus.connect_request),
        .i_en    (r_state == ST_CONNECTING),
        .i_limit (C_DELAY_LIMIT),
        .o_done  (w_delay_done)
    );

    // Disconnect hold only runs inside DROPPED
    terminal_count_counter #(.WIDTH(CNT_W)) u_hold_cnt (
        .clk     (clock),
        .rst     (reset),
        .i_clear (!bus.power_enable || (r_state != ST_DROPPED)),
        .i_en    (r_state == ST_DROPPED),
        .i_limit (C_HOLD_LIMIT),
        .o_done  (w_hold_done)
    );

    // Next-state logic: power loss beats everything, then force_drop
    always_comb begin
        w_state_nxt = r_state;
        if (!bus.power_enable) begin
            w_state_nxt = ST_OFF;
        end else begin
            case (r_state)
                ST_OFF:        w_state_nxt = ST_ADVERTISE;
                ST_ADVERTISE:  if (bus.connect_request) w_state_nxt = ST_CONNECTING;
                ST_CONNECTING: begin
                    if (!bus.connect_request) w_state_nxt = ST_ADVERTISE;
                    else if (w_delay_done)    w_state_nxt = ST_CONNECTED;
                end
                ST_CONNECTED:  if (bus.force_drop || !bus.connect_request) w_state_nxt = ST_DROPPED;
                ST_DROPPED:    if (w_hold_done) w_state_nxt = ST_ADVERTISE;
                default:       w_state_nxt = ST_OFF;
            endcase
        end
    end

    // Next blink bit and line level derived from the next state
    always_comb begin
        w_blink_nxt = 1'b0;
        if (w_nxt_blink && w_in_blink) begin
            w_blink_nxt = r_blink ^ w_blink_done;
        end
        case (w_state_nxt)
            ST_ADVERTISE, ST_CONNECTING: w_line_nxt = w_blink_nxt;
            ST_CONNECTED:                w_line_nxt = 1'b1;
            default:                     w_line_nxt = 1'b0;
        endcase
    end

    // State register and registered outputs, all updated on the same edge
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= ST_OFF;
            r_blink      <= 1'b0;
            r_line       <= 1'b0;
            r_link       <= LS_OFF;
            r_conn       <= 1'b0;
`ifdef HM10_STATE_GEN_TOGGLE_COUNT_EN
            r_toggle_cnt <= 16'd0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_blink <= w_blink_nxt;
            r_line  <= w_line_nxt;
            r_link  <= link_code(w_state_nxt);
            r_conn  <= (w_state_nxt == ST_CONNECTED);
`ifdef HM10_STATE_GEN_TOGGLE_COUNT_EN
            if (w_state_nxt == ST_OFF) begin
                r_toggle_cnt <= 16'd0;
            end else if (w_line_nxt != r_line) begin
                r_toggle_cnt <= r_toggle_cnt + 16'd1;
            end
`endif
        end
    end

    assign bus.state_line   = r_line;
    assign bus.link_state   = r_link;
    assign bus.connected    = r_conn;
`ifdef HM10_STATE_GEN_TOGGLE_COUNT_EN
    assign bus.toggle_count = r_toggle_cnt;
`endif

endmodule
`default_nettype wire
